// File: rtl/fir_decim_buffer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_decim_buffer_if                                              |
// | Sample-in / decimated-result-out bundle for fir_decim_buffer.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fir_decim_buffer_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic signed [DATA_W-1:0] input_sig;
   logic                     in_en;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [FILL_W-1:0]        fill;
   logic                     overflow;

   // master: the decimator itself; slave: whoever feeds it and drains it
   modport master (
      input  input_sig, in_en, out_ready,
      output out_data, out_valid, fill, overflow
   );

   modport slave (
      output input_sig, in_en, out_ready,
      input  out_data, out_valid, fill, overflow
   );
endinterface
`default_nettype wire

// File: rtl/fir_decim_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_decim_buffer                                                 |
// | Accumulate-and-dump decimator feeding a show-ahead result FIFO.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fir_decim_buffer #(
   parameter int DATA_W     = 8,
   parameter int DECIM_LOG2 = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   fir_decim_buffer_if.master bus
);
   localparam int ACC_W  = DATA_W + DECIM_LOG2;
   localparam int PH_W   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [PH_W-1:0]   LAST_PHASE = PH_W'((1 << DECIM_LOG2) - 1);
   localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(FIFO_DEPTH);

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [PH_W-1:0]          phase_q, phase_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0]        fill_q, fill_d;
   logic                     overflow_q, overflow_d;
   logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic signed [DATA_W-1:0] mem_d [FIFO_DEPTH];

   logic signed [ACC_W-1:0]  sample;
   logic signed [ACC_W-1:0]  sum;
   logic signed [DATA_W-1:0] result;
   logic                     dump;
   logic                     pop;
   logic                     full;
   logic                     push;

   always_comb begin
      sample = ACC_W'(bus.input_sig);
      sum    = acc_q + sample;
      // Arithmetic shift floors; the mean of D samples always fits DATA_W.
      result = DATA_W'(sum >>> DECIM_LOG2);
      dump   = bus.in_en && (phase_q == LAST_PHASE);
      pop    = (fill_q != '0) && bus.out_ready;
      full   = (fill_q == FULL_LEVEL);
      // A same-edge pop frees the slot, so a full FIFO can still take the push.
      push   = dump && (!full || pop);
   end

   always_comb begin
      acc_d   = acc_q;
      phase_d = phase_q;
      if (bus.in_en) begin
         if (dump) begin
            acc_d   = '0;
            phase_d = '0;
         end else begin
            acc_d   = sum;
            phase_d = phase_q + PH_W'(1);
         end
      end
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      overflow_d = overflow_q | (dump && full && !pop);
      if (push) begin
         mem_d[wr_ptr_q] = result;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + FILL_W'(1);
         2'b01:   fill_d = fill_q - FILL_W'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         phase_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         acc_q      <= acc_d;
         phase_q    <= phase_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

   always_comb begin
      bus.out_valid = (fill_q != '0);
      bus.out_data  = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
      bus.fill      = fill_q;
      bus.overflow  = overflow_q;
   end

endmodule
`default_nettype wire
